// File: rtl/axis_disp_pkg.sv
// Shared types and constants for the axis BCD display sequencer.
// Optional AXIS_TEMP_SCAN_EN adds the temperature slot (sel=11) to the scan.
package axis_disp_pkg;

    typedef enum logic [2:0] {
        SETTLE,
        CAPTURE,
        CONVERT,
        PUBLISH,
        DWELL
    } state_t;

    localparam logic [1:0] SEL_X = 2'b00;
    localparam logic [1:0] SEL_Y = 2'b01;
    localparam logic [1:0] SEL_Z = 2'b10;
    localparam logic [1:0] SEL_T = 2'b11;

    localparam int BCD_DIGITS = 5;
    localparam int BIN_W      = 16;
    localparam int SR_W       = 36;
    localparam int CONV_ITERS = 16;

    // One double-dabble step: correct every BCD nibble, then shift left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (t[BIN_W+4*d +: 4] >= 4'd5)
                t[BIN_W+4*d +: 4] = t[BIN_W+4*d +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative 16-bit binary to 5-digit BCD converter, one bit per cycle.
// done flags the cycle in which the final iteration is performed.
module bin2bcd_iter
    import axis_disp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam logic [4:0] LAST_ITER = 5'(CONV_ITERS - 1);

    logic [SR_W-1:0] sr;
    logic [4:0]      iter;

    assign done = busy && (iter == LAST_ITER);
    assign bcd  = sr[SR_W-1:BIN_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            iter <= '0;
            busy <= 1'b0;
        end else if (load) begin
            sr   <= {{(SR_W-BIN_W){1'b0}}, bin};
            iter <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            sr   <= dabble_step(sr);
            iter <= iter + 5'd1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_bcd_sequencer.sv
// Scans the gyro axes through the mux, converts each sample to sign+BCD
// and publishes it for a dwell time. AXIS_TEMP_SCAN_EN adds sel=11 (unsigned).
module axis_bcd_sequencer
    import axis_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] data,
    output logic [1:0]  sel,
    output logic [19:0] bcd,
    output logic        sign,
    output logic [1:0]  axis,
    output logic        valid
);

    localparam int            DW         = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    state_t            state, state_n;
    logic [DW-1:0]     dwell_cnt;
    logic              sign_w;
    logic              sign_c;
    logic [BIN_W-1:0]  mag_c;
    logic [1:0]        sel_n;
    logic              load, publish, advance;
    logic              conv_busy, conv_done;
    logic [19:0]       conv_bcd;

    always_comb begin
        sign_c = data[15];
        mag_c  = data[15] ? (~data + 16'd1) : data;
`ifdef AXIS_TEMP_SCAN_EN
        if (sel == SEL_T) begin
            sign_c = 1'b0;
            mag_c  = data;
        end
        sel_n = sel + 2'd1;
`else
        sel_n = (sel == SEL_Z) ? SEL_X : sel + 2'd1;
`endif
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        publish = 1'b0;
        advance = 1'b0;
        unique case (state)
            SETTLE:  state_n = CAPTURE;
            CAPTURE: begin
                load    = 1'b1;
                state_n = CONVERT;
            end
            CONVERT: if (conv_done || !conv_busy) state_n = PUBLISH;
            PUBLISH: begin
                publish = 1'b1;
                state_n = DWELL;
            end
            DWELL: if (en && dwell_cnt == DWELL_LAST) begin
                advance = 1'b1;
                state_n = SETTLE;
            end
            default: state_n = SETTLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= SETTLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel       <= SEL_X;
            bcd       <= '0;
            sign      <= 1'b0;
            axis      <= SEL_X;
            valid     <= 1'b0;
            sign_w    <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            valid <= publish;
            if (load)
                sign_w <= sign_c;
            if (publish) begin
                bcd       <= conv_bcd;
                sign      <= sign_w;
                axis      <= sel;
                dwell_cnt <= '0;
            end else if (state == DWELL && en) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
            if (advance)
                sel <= sel_n;
        end
    end

    bin2bcd_iter u_conv (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .bin  (mag_c),
        .busy (conv_busy),
        .done (conv_done),
        .bcd  (conv_bcd)
    );

endmodule

// File: tb/tb_axis_bcd_sequencer.sv
// Randomized bench for axis_bcd_sequencer against a decimal-arithmetic model.
// Build with AXIS_TEMP_SCAN_EN to cover the four-slot scan.
module tb_axis_bcd_sequencer;

    localparam int DWELL = 4;
`ifdef AXIS_TEMP_SCAN_EN
    localparam int N_AX = 4;
`else
    localparam int N_AX = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] data;
    logic [1:0]  sel;
    logic [19:0] bcd;
    logic        sign;
    logic [1:0]  axis;
    logic        valid;

    logic [15:0] axis_val [4];
    logic        override;
    logic [15:0] ov_val;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ref_cyc = 0;
    int exp_ax = 0;
    logic [15:0] exp_data;

    assign data = override ? ov_val : axis_val[sel];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_bcd_sequencer #(.DWELL_CYCLES(DWELL)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .data  (data),
        .sel   (sel),
        .bcd   (bcd),
        .sign  (sign),
        .axis  (axis),
        .valid (valid)
    );

    task automatic check(input string tag, input int unsigned act,
                         input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: decimal digits of the magnitude, sign from the slot rules.
    function automatic logic [20:0] model(input int ax, input logic [15:0] d);
        int m;
        logic s;
        logic [19:0] b;
        if (ax == 3) begin
            m = int'(d);
            s = 1'b0;
        end else begin
            m = int'($signed(d));
            s = (m < 0);
            if (m < 0) m = -m;
        end
        b = '0;
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {s, b};
    endfunction

    function automatic logic [15:0] rnd_val();
        logic [15:0] corner [4];
        corner[0] = 16'h8000;
        corner[1] = 16'h7FFF;
        corner[2] = 16'hFFFF;
        corner[3] = 16'h0000;
        if ($urandom_range(0, 3) == 0)
            return corner[$urandom_range(0, 3)];
        return 16'($urandom);
    endfunction

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("valid_timeout", 0, 1);
    endtask

    task automatic wait_sel_change(output int n);
        logic [1:0] old;
        old = sel;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (sel != old) break;
        end
    endtask

    task automatic expect_result(input int lat, input logic [15:0] nv);
        logic [20:0] e;
        bit got;
        wait_valid(got);
        if (got) begin
            e = model(exp_ax, exp_data);
            check("latency", cyc - ref_cyc, lat);
            check("axis", axis, exp_ax);
            check("bcd", bcd, e[19:0]);
            check("sign", sign, e[20]);
            ref_cyc = cyc;
            exp_ax = (exp_ax + 1) % N_AX;
            exp_data = nv;
            axis_val[exp_ax] = nv;
            @(posedge clk);
            #1;
            check("valid_pulse", valid, 0);
            check("bcd_hold", bcd, e[19:0]);
        end
    endtask

    initial begin
        int n;
        int sel_moves;
        int stray_valid;
        logic [1:0] sel0;

        for (int i = 0; i < 4; i++) axis_val[i] = 16'h0000;
        override = 1'b0;
        ov_val = '0;
        en = 1'b1;
        rst = 1'b1;
        exp_ax = 0;
        exp_data = 16'h7FFF;
        axis_val[0] = 16'h7FFF;

        repeat (3) @(posedge clk);
        #1;
        check("rst_sel", sel, 0);
        check("rst_bcd", bcd, 0);
        check("rst_sign", sign, 0);
        check("rst_axis", axis, 0);
        check("rst_valid", valid, 0);

        @(negedge clk);
        rst = 1'b0;
        ref_cyc = cyc;

        expect_result(19, 16'hFFFF);
        expect_result(23, 16'h8000);
`ifdef AXIS_TEMP_SCAN_EN
        expect_result(23, 16'h00FF);
`endif
        expect_result(23, 16'h0000);
        expect_result(23, rnd_val());
        repeat (7) expect_result(23, rnd_val());
        expect_result(23, 16'h0400);

        // Capture 0x0400, then scramble data for the whole conversion.
        wait_sel_change(n);
        check("sel_advance", n, DWELL - 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        override = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ov_val = 16'($urandom);
            @(posedge clk);
            #1;
        end
        override = 1'b0;
        expect_result(23, rnd_val());

        // Drop en mid-conversion, hold it low, then resume.
        wait_sel_change(n);
        check("sel_advance2", n, DWELL - 1);
        repeat (5) @(posedge clk);
        #1;
        en = 1'b0;
        expect_result(23, rnd_val());
        sel0 = sel;
        sel_moves = 0;
        stray_valid = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (sel != sel0) sel_moves++;
            if (valid) stray_valid++;
        end
        check("en_low_sel_hold", sel_moves, 0);
        check("en_low_no_valid", stray_valid, 0);
        en = 1'b1;
        wait_sel_change(n);
        check("en_resume", n, DWELL);
        ref_cyc = cyc;
        expect_result(19, rnd_val());

        // Reset at iteration 8 of a conversion.
        wait_sel_change(n);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_sel", sel, 0);
        check("midrst_bcd", bcd, 0);
        check("midrst_sign", sign, 0);
        check("midrst_axis", axis, 0);
        check("midrst_valid", valid, 0);
        exp_ax = 0;
        exp_data = rnd_val();
        axis_val[0] = exp_data;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_cyc = cyc;
        expect_result(19, rnd_val());
        expect_result(23, rnd_val());
        expect_result(23, rnd_val());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_bcd_sequencer.md
Name: axis_bcd_sequencer

Overview:
Downstream consumer of the axis multiplexer. It drives the mux select, so the three gyro axes are visited in turn. For each axis it captures the 16-bit two's-complement sample and converts the magnitude to 5-digit BCD with an iterative double-dabble. It then publishes sign + BCD to the seven-segment/display driver, holding each result for a programmable dwell time.

Parameters:
DWELL_CYCLES, 100000000, clk cycles each published result is held before advancing to the next axis (min 1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  1 = dwell counter runs; 0 = freeze in DWELL (conversions already started finish)
data  input  16  signed axis sample from the mux, combinationally dependent on sel
sel  output  2  axis select driven to the mux: 00 x, 01 y, 10 z
bcd  output  20  published magnitude, 5 BCD digits, [19:16] = ten-thousands
sign  output  1  published sign, 1 = negative
axis  output  2  sel value the published result belongs to
valid  output  1  one-cycle pulse when bcd/sign/axis update

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: sel=00, bcd=0, sign=0, axis=00, valid=0, state=SETTLE, dwell counter=0, iteration counter=0.
- FSM, all transitions on rising clk:
  - SETTLE: 1 cycle for the mux output to settle after a sel change. Goes to CAPTURE.
  - CAPTURE: latches data. sign_w = data[15]. mag = data[15] ? (~data+1) : data, as a 16-bit unsigned value, so 0x8000 gives 32768. Loads a 36-bit shift register {20'b0, mag}, clears the iteration counter, goes to CONVERT.
  - CONVERT: exactly 16 iterations, one per cycle. Each BCD nibble >=5 gets +3, then the register shifts left 1. After the 16th iteration, goes to PUBLISH.
  - PUBLISH: registers bcd <= sr[35:16], sign <= sign_w, axis <= sel, valid <= 1 for one cycle. Clears the dwell counter and goes to DWELL.
  - DWELL: while en=1 the counter increments. On the cycle the counter equals DWELL_CYCLES-1, sel advances 00->01->10->00 and the state goes to SETTLE. While en=0 the counter and sel hold.
- Latency: sel change at edge T gives valid high after edge T+19. After reset release, first valid follows the 19th rising edge. Result period = 19+DWELL_CYCLES cycles with en=1.
- Changes on data after CAPTURE do not affect the in-flight result.
- Outputs bcd/sign/axis hold between PUBLISH events.
- Reset mid-CONVERT or mid-DWELL: immediate return to reset values; the partial result is discarded.
- en deasserted in SETTLE/CAPTURE/CONVERT/PUBLISH: the sequence completes through PUBLISH, then holds in DWELL.
- Dwell counter width is $clog2(DWELL_CYCLES+1); iteration counter is 5 bits.

Optional Feature:
AXIS_TEMP_SCAN_EN
- Defined: sel sequence is 00->01->10->11->00. When sel=11 the captured data is treated as unsigned: sign forced 0, mag = data, no negation.
- Undefined: sel never reaches 11 and the wrap is 10->00. The logic for the 11 state is not generated.

Decomposition:
- Package axis_disp_pkg holds:
  - state enum {SETTLE, CAPTURE, CONVERT, PUBLISH, DWELL}
  - sel encodings SEL_X=2'b00, SEL_Y=2'b01, SEL_Z=2'b10, SEL_T=2'b11
  - constants BCD_DIGITS=5, BIN_W=16, SR_W=36, CONV_ITERS=16
- Sub-module bin2bcd_iter holds the shift register, add-3 logic and iteration counter, with load/busy/done signals. The sequencer FSM instantiates it, so CONVERT waits on done.

Test Plan:
- Reset, x-data held at 0x7FFF, DWELL_CYCLES=4 -> valid after 19th edge; bcd=0x32767, sign=0, axis=00.
- y-data 0xFFFF -> result for axis 01: bcd=0x00001, sign=1; z-data 0x8000 -> axis 10: bcd=0x32768, sign=1; x 0x0000 -> bcd=0, sign=0.
- DWELL_CYCLES=4, en=1 continuous -> valid pulses exactly 23 cycles apart, axis sequence 00,01,10,00. With AXIS_TEMP_SCAN_EN, the sequence includes 11 and data 0x00FF there gives bcd=0x00255, sign=0.
- Data toggled every cycle during CONVERT after capturing 0x0400 -> bcd=0x01024, unaffected.
- rst pulsed at iteration 8 of CONVERT -> all outputs 0 and sel=00 that cycle; next valid 19 edges after release.
- en dropped during CONVERT -> PUBLISH still pulses valid. Sel stays constant for 50 cycles with en=0; after en rises, sel advances after DWELL_CYCLES cycles.
